// File: rtl/tag_allocator.sv
// Rename-tag allocator for the ALU and LS reservation stations.
// Each pool keeps a busy bitmap and a free count, and offers its lowest free
// root to the dispatcher every cycle. Dispatch consumes the offered root,
// station releases return roots, and flush returns everything to free.

module tag_pool #(
  parameter int ENTRIES = 16,
  parameter int ROOT_W  = 4,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc,
  input  logic              rel_en,
  input  logic [ROOT_W-1:0] rel_tag,
  input  logic              flush,
  output logic [ROOT_W-1:0] free_tag,
  output logic              full,
  output logic [CNT_W-1:0]  free_cnt,
  output logic              rel_bad
);

  logic [ENTRIES-1:0] busy;
  logic [ENTRIES-1:0] pick_mask;
  logic [ENTRIES-1:0] rel_mask;
  logic [ROOT_W-1:0]  pick_tag;
  logic               pick_found;
  logic               rel_hit;
  logic               alloc_ok;

  // Lowest-index free root: first zero bit scanning upward from root 0.
  always_comb begin
    pick_tag   = '0;
    pick_mask  = '0;
    pick_found = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!pick_found && !busy[i]) begin
        pick_tag     = ROOT_W'(i);
        pick_mask[i] = 1'b1;
        pick_found   = 1'b1;
      end
    end
  end

  // One-hot decode of the released root; an out-of-range root decodes to zero.
  always_comb begin
    rel_mask = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      rel_mask[i] = rel_en && (rel_tag == ROOT_W'(i));
    end
  end

  // A release only counts if it hits a busy, in-range root.
  assign rel_hit  = |(rel_mask & busy);
  assign rel_bad  = rel_en & ~rel_hit;
  assign full     = &busy;
  assign alloc_ok = alloc & ~full;
  assign free_tag = full ? '0 : pick_tag;

  // Bitmap and count update; flush wins over any same-cycle alloc/release.
  // The allocated root is free and the released root is busy, so the two
  // masks never overlap and can be applied together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      free_cnt <= CNT_W'(ENTRIES);
    end else if (flush) begin
      busy     <= '0;
      free_cnt <= CNT_W'(ENTRIES);
    end else begin
      busy     <= (busy | (alloc_ok ? pick_mask : '0)) & ~(rel_hit ? rel_mask : '0);
      free_cnt <= free_cnt + CNT_W'(rel_hit) - CNT_W'(alloc_ok);
    end
  end

endmodule

module tag_allocator #(
  parameter int ALU_ENTRIES = 16,
  parameter int LS_ENTRIES  = 8,
  parameter int ROOT_W      = 4,
  parameter int CNT_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dispValid,
  input  logic              dispIsLS,
  input  logic              aluRelEn,
  input  logic [ROOT_W-1:0] aluRelTag,
  input  logic              lsRelEn,
  input  logic [ROOT_W-1:0] lsRelTag,
  input  logic              flush,
  output logic [ROOT_W-1:0] ALUfreeTag,
  output logic [ROOT_W-1:0] LSfreeTag,
  output logic              aluFull,
  output logic              lsFull,
  output logic              stall,
  output logic [CNT_W-1:0]  aluFreeCnt,
  output logic [CNT_W-1:0]  lsFreeCnt,
  output logic              relErr
);

  logic alu_alloc;
  logic ls_alloc;
  logic alu_rel_bad;
  logic ls_rel_bad;

  // Stall is suppressed during flush since no allocation happens then anyway.
  assign stall     = dispValid & ~flush & (dispIsLS ? lsFull : aluFull);
  assign alu_alloc = dispValid & ~dispIsLS & ~aluFull & ~flush;
  assign ls_alloc  = dispValid &  dispIsLS & ~lsFull  & ~flush;

  tag_pool #(
    .ENTRIES (ALU_ENTRIES),
    .ROOT_W  (ROOT_W),
    .CNT_W   (CNT_W)
  ) u_alu_pool (
    .clk      (clk),
    .rst_n    (rst),
    .alloc    (alu_alloc),
    .rel_en   (aluRelEn),
    .rel_tag  (aluRelTag),
    .flush    (flush),
    .free_tag (ALUfreeTag),
    .full     (aluFull),
    .free_cnt (aluFreeCnt),
    .rel_bad  (alu_rel_bad)
  );

  tag_pool #(
    .ENTRIES (LS_ENTRIES),
    .ROOT_W  (ROOT_W),
    .CNT_W   (CNT_W)
  ) u_ls_pool (
    .clk      (clk),
    .rst_n    (rst),
    .alloc    (ls_alloc),
    .rel_en   (lsRelEn),
    .rel_tag  (lsRelTag),
    .flush    (flush),
    .free_tag (LSfreeTag),
    .full     (lsFull),
    .free_cnt (lsFreeCnt),
    .rel_bad  (ls_rel_bad)
  );

  // Sticky release-error flag; releases coinciding with flush are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      relErr <= 1'b0;
    end else if (!flush && (alu_rel_bad || ls_rel_bad)) begin
      relErr <= 1'b1;
    end
  end

endmodule

// File: doc/tag_allocator.md
Name: tag_allocator

Overview:
- Manages the rename-tag pools of the ALU and LS reservation stations.
- Keeps one free bitmap per pool and offers the lowest free tag root to the dispatcher every cycle (ALUfreeTag / LSfreeTag).
- Marks a tag busy when dispatch consumes it and frees it when the owning station releases the entry.
- Raises per-pool full and a dispatch stall so no instruction issues without a tag; supports flush on mispredict.

Parameters:
ALU_ENTRIES, 16, number of ALU tag roots (indices 0..ALU_ENTRIES-1)
LS_ENTRIES, 8, number of LS tag roots (indices 0..LS_ENTRIES-1)
ROOT_W, 4, tag root width; must satisfy 2^ROOT_W >= max(ALU_ENTRIES, LS_ENTRIES)
CNT_W, 5, free-count width; must hold ALU_ENTRIES

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
dispValid  in  1  dispatcher presents an instruction this cycle
dispIsLS  in  1  1 = LD/ST class (LS pool), 0 = any other class (ALU pool)
aluRelEn  in  1  ALU station frees one entry
aluRelTag  in  ROOT_W  root being freed by ALU station
lsRelEn  in  1  LS station frees one entry
lsRelTag  in  ROOT_W  root being freed by LS station
flush  in  1  mispredict/clear: every tag returns to free
ALUfreeTag  out  ROOT_W  lowest-index free ALU root; 0 when aluFull
LSfreeTag  out  ROOT_W  lowest-index free LS root; 0 when lsFull
aluFull  out  1  no ALU root free
lsFull  out  1  no LS root free
stall  out  1  dispValid & (dispIsLS ? lsFull : aluFull)
aluFreeCnt  out  CNT_W  number of free ALU roots
lsFreeCnt  out  CNT_W  number of free LS roots
relErr  out  1  sticky: a release targeted an already-free or out-of-range root

Behaviour:
- State: aluBusy[ALU_ENTRIES], lsBusy[LS_ENTRIES], aluFreeCnt, lsFreeCnt, relErr. All are registers.
- Reset (rst=0, asynchronous):
  - all busy bits 0; aluFreeCnt=ALU_ENTRIES; lsFreeCnt=LS_ENTRIES; relErr=0.
  - Resulting outputs: ALUfreeTag=0, LSfreeTag=0, aluFull=0, lsFull=0, stall=0.
  - Reset mid-operation discards all allocations immediately.
- Outputs ALUfreeTag, LSfreeTag, aluFull, lsFull and stall are combinational from the registered bitmaps plus dispValid/dispIsLS. No input-to-tag combinational path exists.
- Allocation:
  - Condition: dispValid & !stall.
  - Effect at the next rising edge: the offered root of the selected pool (ALUfreeTag or LSfreeTag) sets its busy bit; that pool's count decrements by 1.
  - Allocation latency is 1 cycle. The following cycle offers the next lowest free root, so back-to-back dispatch to one pool gets 0, 1, 2, ...
  - The non-selected pool is unchanged.
- Release:
  - aluRelEn clears aluBusy[aluRelTag] at the next edge and increments aluFreeCnt. LS release is identical and independent.
  - Both pools may release in the same cycle.
  - Release of a root that is already free, or a root >= the pool's entry count: no state change and no count change; relErr sets to 1 and stays set until reset.
- Simultaneous allocation and release in the same pool, same cycle:
  - The allocated root is free and the released root is busy, so they differ; both are applied.
  - Net count is unchanged.
  - The freed root is not offered until the next cycle, so no same-cycle bypass.
- Full pool:
  - Full = all busy. The free tag reads 0 and stall is asserted whenever dispValid targets that pool.
  - A release in a full cycle clears full at the next edge.
  - A dispatch to the other, non-full pool proceeds.
- Flush:
  - All busy bits are cleared and both counts return to maximum at the next edge.
  - Flush overrides any allocation or release in the same cycle; no relErr is raised for releases that coincide with a flush.
  - stall is forced to 0 during the flush cycle.
- Invariant: aluFreeCnt equals the number of zero bits in aluBusy (same for LS). Counts never underflow or overflow.

Test Plan:
1. Release rst after 3 cycles -> ALUfreeTag=0, LSfreeTag=0, aluFreeCnt=16, lsFreeCnt=8, stall=0.
2. 16 consecutive ALU dispatches (dispIsLS=0) -> ALUfreeTag sequence 0..15, aluFreeCnt 16->0. After the 16th: aluFull=1, ALUfreeTag=0; a 17th dispValid gives stall=1 and the bitmap is unchanged.
3. With the ALU pool full, aluRelEn with tag 5 -> next cycle aluFull=0, ALUfreeTag=5, aluFreeCnt=1. A simultaneous LS dispatch in the full cycle proceeds with LSfreeTag=0.
4. LS roots 0..3 busy; same cycle LS dispatch plus lsRelTag=2 -> root 4 allocated and root 2 freed, lsFreeCnt stays 4, next LSfreeTag=2.
5. Release of free ALU root 9, then release of LS root 12 (>7) -> relErr=1 after the first, still 1 after the second, counts unchanged; only rst clears it.
6. Both pools partially busy; flush with dispValid=1 and aluRelEn=1 in the same cycle -> stall=0 that cycle; next cycle all free, counts 16/8, no allocation recorded, relErr unchanged. Also: rst pulled low mid-allocation clears state asynchronously, before the next clock edge.
